// File: rtl/round_controller_pkg.sv
// Shared types and defaults for the round controller: FSM states, field widths
// and the default round/cooldown lengths.
package round_controller_pkg;

  localparam int ROUND_SECONDS_DEFAULT  = 60;
  localparam int COOLDOWN_TICKS_DEFAULT = 3;

  localparam int SECONDS_W = 6;
  localparam int COOL_W    = 4;
  localparam int ROUNDS_W  = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    EXPIRE   = 2'd2,
    COOLDOWN = 2'd3
  } round_state_t;

endpackage

// File: rtl/round_controller_if.sv
// Button/timer-facing signal bundle of the round controller; the controller
// uses the slave view, whoever drives buttons and ticks uses the master view.
interface round_controller_if;
  import round_controller_pkg::*;

  logic                 start_btn;
  logic                 stop_btn;
  logic                 sec_tick;
  logic                 timesup;
  logic                 start_timer;
  logic [SECONDS_W-1:0] seconds_left;
  logic                 round_active;
  logic                 round_done;
  logic [ROUNDS_W-1:0]  rounds_played;

  modport master (
    output start_btn, stop_btn, sec_tick, timesup,
    input  start_timer, seconds_left, round_active, round_done, rounds_played
  );

  modport slave (
    input  start_btn, stop_btn, sec_tick, timesup,
    output start_timer, seconds_left, round_active, round_done, rounds_played
  );

endinterface

// File: rtl/round_controller_sec_countdown.sv
// Loadable down-counter advanced by one-cycle ticks; stops at zero rather
// than wrapping and flags when it sits at zero.
module sec_countdown #(
  parameter int               WIDTH       = 6,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             tick,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  assign zero = (count == '0);

  // Load takes priority so a tick on a reload cycle is dropped.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= RESET_VALUE;
    end else if (load) begin
      count <= load_value;
    end else if (tick && !zero) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/round_controller.sv
// Game round sequencer: IDLE -> RUN -> EXPIRE -> COOLDOWN -> IDLE, driving a
// downstream timer and reporting remaining seconds and completed rounds.
module round_controller
  import round_controller_pkg::*;
#(
  parameter int ROUND_SECONDS  = ROUND_SECONDS_DEFAULT,
  parameter int COOLDOWN_TICKS = COOLDOWN_TICKS_DEFAULT
) (
  input logic               clock,
  input logic               reset,
  round_controller_if.slave bus
);

  localparam logic [SECONDS_W-1:0] ROUND_LOAD = SECONDS_W'(ROUND_SECONDS);
  localparam logic [COOL_W-1:0]    COOL_LOAD  = COOL_W'(COOLDOWN_TICKS);

  round_state_t state_reg, state_next;

  logic                 secs_load, secs_tick;
  logic [SECONDS_W-1:0] secs_load_value, secs_count;
  logic                 secs_zero_unused;
  logic                 cool_load, cool_tick, cool_zero;
  logic [COOL_W-1:0]    cool_count_unused;

  logic                start_timer_reg, start_timer_next;
  logic                round_active_reg, round_active_next;
  logic                round_done_reg, round_done_next;
  logic [ROUNDS_W-1:0] rounds_reg, rounds_next;

  sec_countdown #(.WIDTH(SECONDS_W), .RESET_VALUE(ROUND_LOAD)) u_seconds (
    .clock      (clock),
    .reset      (reset),
    .load       (secs_load),
    .load_value (secs_load_value),
    .tick       (secs_tick),
    .count      (secs_count),
    .zero       (secs_zero_unused)
  );

  sec_countdown #(.WIDTH(COOL_W), .RESET_VALUE('0)) u_cooldown (
    .clock      (clock),
    .reset      (reset),
    .load       (cool_load),
    .load_value (COOL_LOAD),
    .tick       (cool_tick),
    .count      (cool_count_unused),
    .zero       (cool_zero)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // timesup is checked before stop_btn so a simultaneous abort still counts the round.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (bus.start_btn) state_next = RUN;
      RUN: begin
        if (bus.timesup)       state_next = EXPIRE;
        else if (bus.stop_btn) state_next = IDLE;
      end
      EXPIRE:   state_next = COOLDOWN;
      COOLDOWN: if (cool_zero) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Ticks are only consumed by the state currently occupied; the entry
  // reloads override any tick landing on a transition edge.
  always_comb begin
    secs_load       = 1'b0;
    secs_load_value = ROUND_LOAD;
    secs_tick       = (state_reg == RUN) && bus.sec_tick;
    cool_load       = (state_reg == EXPIRE);
    cool_tick       = (state_reg == COOLDOWN) && bus.sec_tick;
    if (state_next == IDLE) begin
      secs_load = 1'b1;
    end else if (state_next == EXPIRE) begin
      secs_load       = 1'b1;
      secs_load_value = '0;
    end

    start_timer_next  = (state_next == RUN);
    round_active_next = (state_next == RUN);
    round_done_next   = (state_next == EXPIRE);
    rounds_next       = rounds_reg;
    if (state_next == EXPIRE && rounds_reg != '1) begin
      rounds_next = rounds_reg + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      start_timer_reg  <= 1'b0;
      round_active_reg <= 1'b0;
      round_done_reg   <= 1'b0;
      rounds_reg       <= '0;
    end else begin
      start_timer_reg  <= start_timer_next;
      round_active_reg <= round_active_next;
      round_done_reg   <= round_done_next;
      rounds_reg       <= rounds_next;
    end
  end

  assign bus.start_timer   = start_timer_reg;
  assign bus.round_active  = round_active_reg;
  assign bus.round_done    = round_done_reg;
  assign bus.rounds_played = rounds_reg;
  assign bus.seconds_left  = secs_count;

endmodule

// File: doc/round_controller.md
ROUND_CONTROLLER -- requirements
Module: round_controller

Interface
REQ-001 Parameter ROUND_SECONDS, default 60, round length in seconds; SHALL be 1..63.
REQ-002 Parameter COOLDOWN_TICKS, default 3, seconds of lockout after a round; SHALL be 1..15.
REQ-003 clock  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 start_btn  in  1  debounced one-cycle pulse requesting a new round.
REQ-006 stop_btn  in  1  debounced one-cycle pulse aborting the current round.
REQ-007 sec_tick  in  1  one-cycle strobe, once per second, same cadence that advances the downstream timer.
REQ-008 timesup  in  1  level from downstream timer; high once its minute has elapsed while start_timer is held.
REQ-009 start_timer  out  1  level enabling the downstream timer; low clears it.
REQ-010 seconds_left  out  6  remaining seconds of current round, for display.
REQ-011 round_active  out  1  high while a round is running.
REQ-012 round_done  out  1  one-cycle pulse on normal round expiry.
REQ-013 rounds_played  out  4  count of completed (not aborted) rounds.

Function
REQ-014 FSM states SHALL be IDLE, RUN, EXPIRE, COOLDOWN; all outputs registered.
REQ-015 IDLE: start_timer=0, round_active=0, seconds_left=ROUND_SECONDS; start_btn -> RUN, start_timer high on the following cycle (latency 1).
REQ-016 RUN: start_timer=1, round_active=1; each sec_tick decrements seconds_left, saturating at 0 (no wrap).
REQ-017 RUN: timesup=1 -> EXPIRE; stop_btn=1 -> IDLE with no round_done and no rounds_played change.
REQ-018 RUN: timesup and stop_btn in the same cycle -> timesup wins (EXPIRE).
REQ-019 RUN: start_btn SHALL be ignored (no restart).
REQ-020 EXPIRE: lasts exactly one cycle; round_done=1, seconds_left=0, start_timer=0, round_active=0; rounds_played increments, saturating at 15; -> COOLDOWN.
REQ-021 COOLDOWN: start_timer=0; counts COOLDOWN_TICKS sec_ticks, then -> IDLE on the cycle after the last tick; start_btn ignored.
REQ-022 sec_tick coincident with a state transition SHALL be applied in the originating state only.
REQ-023 start_timer SHALL be low for at least one cycle between any two rounds, so the downstream timer clears.

Reset
REQ-024 reset high SHALL immediately force IDLE, start_timer=0, round_active=0, round_done=0, seconds_left=ROUND_SECONDS, rounds_played=0, cooldown count=0.
REQ-025 reset asserted mid-RUN or mid-COOLDOWN SHALL abort with no round_done pulse.

Structure
REQ-026 Shared package SHALL hold the state enumeration and the ROUND_SECONDS/COOLDOWN_TICKS defaults.
REQ-027 One sub-module, sec_countdown (load, tick, saturating-decrement, zero flag), SHALL serve both seconds_left and the cooldown count.

Verification
REQ-028 reset release, start_btn pulse -> start_timer=1 and round_active=1 one cycle later; seconds_left=60.
REQ-029 In RUN, 60 sec_ticks then timesup=1 -> seconds_left=0, single round_done pulse, rounds_played 0->1, start_timer=0.
REQ-030 stop_btn after 10 sec_ticks -> IDLE, seconds_left=60, rounds_played unchanged, no round_done.
REQ-031 timesup and stop_btn same cycle -> round_done pulses, rounds_played increments.
REQ-032 start_btn during COOLDOWN ignored; after 3 sec_ticks -> IDLE, then start_btn accepted; 16 completed rounds -> rounds_played holds 15.
REQ-033 reset asserted mid-RUN with seconds_left=25 -> outputs at reset values without waiting for a clock edge.
